// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: data RAM, branch resolve, MEM/WB register.
// Ports: clock/reset, EX/MEM inputs in_*, branch_*, wb_*, misalign_err, counters.
module mem_access_stage #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_aluout,
    input  logic [31:0]       in_regdatab,
    input  logic              in_cond,
    input  logic [3:0]        in_instnum,
    input  logic [3:0]        in_insttype,
    output logic              branch_taken,
    output logic [31:0]       branch_target,
    output logic              wb_valid,
    output logic [31:0]       wb_inst,
    output logic [31:0]       wb_aluout,
    output logic [31:0]       wb_lmd,
    output logic [3:0]        wb_instnum,
    output logic [3:0]        wb_insttype,
    output logic              misalign_err,
    output logic [15:0]       load_count,
    output logic [15:0]       store_count
);

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              aligned;

    logic is_lw, is_lb, is_lbu, is_sw, is_sb, is_br;
    logic misalign, load_ok, store_ok;
    logic do_sw, do_sb;

    logic [31:0] ram [0:(1<<ADDR_W)-1];
    logic [31:0] rword;
    logic [7:0]  rbyte;
    logic [31:0] lmd_next;

    assign opcode  = in_inst[31:26];
    assign idx     = in_aluout[ADDR_W+1:2];
    assign lane    = in_aluout[1:0];
    assign aligned = (lane == 2'b00);

    assign is_lw  = (opcode == OP_LW);
    assign is_lb  = (opcode == OP_LB);
    assign is_lbu = (opcode == OP_LBU);
    assign is_sw  = (opcode == OP_SW);
    assign is_sb  = (opcode == OP_SB);
    assign is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);

    // Byte accesses can never be misaligned; only word accesses check.
    assign misalign = in_valid && (is_lw || is_sw) && !aligned;
    assign load_ok  = in_valid && ((is_lw && aligned) || is_lb || is_lbu);
    assign store_ok = in_valid && ((is_sw && aligned) || is_sb);

    // Reset blocks any store presented in the same cycle.
    assign do_sw = !reset && in_valid && is_sw && aligned;
    assign do_sb = !reset && in_valid && is_sb;

    assign branch_taken  = in_valid && is_br && in_cond;
    assign branch_target = in_aluout;

    // Read is taken from the pre-edge contents, giving read-before-write.
    assign rword = ram[idx];

    always_comb begin
        rbyte = rword[7:0];
        case (lane)
            2'd0: rbyte = rword[7:0];
            2'd1: rbyte = rword[15:8];
            2'd2: rbyte = rword[23:16];
            2'd3: rbyte = rword[31:24];
            default: rbyte = rword[7:0];
        endcase
    end

    always_comb begin
        lmd_next = 32'd0;
        if (in_valid) begin
            if (is_lw && aligned)
                lmd_next = rword;
            else if (is_lb)
                lmd_next = {{24{rbyte[7]}}, rbyte};
            else if (is_lbu)
                lmd_next = {24'd0, rbyte};
        end
    end

    // RAM has no reset: contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (do_sw)
            ram[idx] <= in_regdatab;
        else if (do_sb)
            ram[idx][{lane, 3'b000} +: 8] <= in_regdatab[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_inst      <= 32'd0;
            wb_aluout    <= 32'd0;
            wb_lmd       <= 32'd0;
            wb_instnum   <= 4'd0;
            wb_insttype  <= 4'd0;
            misalign_err <= 1'b0;
            load_count   <= 16'd0;
            store_count  <= 16'd0;
        end else begin
            wb_valid    <= in_valid;
            wb_inst     <= in_inst;
            wb_aluout   <= in_aluout;
            wb_lmd      <= lmd_next;
            wb_instnum  <= in_instnum;
            wb_insttype <= in_insttype;
            if (misalign)
                misalign_err <= 1'b1;
            if (load_ok && load_count != 16'hFFFF)
                load_count <= load_count + 16'd1;
            if (store_ok && store_count != 16'hFFFF)
                store_count <= store_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random
// traffic compared against a byte-addressed memory model.
module tb_mem_access_stage;

    localparam int ADDR_W = 8;
    localparam int NBYTES = 4 * (1 << ADDR_W);

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_aluout;
    logic [31:0] in_regdatab;
    logic        in_cond;
    logic [3:0]  in_instnum;
    logic [3:0]  in_insttype;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic [31:0] wb_aluout;
    logic [31:0] wb_lmd;
    logic [3:0]  wb_instnum;
    logic [3:0]  wb_insttype;
    logic        misalign_err;
    logic [15:0] load_count;
    logic [15:0] store_count;

    mem_access_stage #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .in_inst(in_inst), .in_aluout(in_aluout),
        .in_regdatab(in_regdatab), .in_cond(in_cond),
        .in_instnum(in_instnum), .in_insttype(in_insttype),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_aluout(wb_aluout),
        .wb_lmd(wb_lmd), .wb_instnum(wb_instnum),
        .wb_insttype(wb_insttype), .misalign_err(misalign_err),
        .load_count(load_count), .store_count(store_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: byte-addressed memory and expected stage outputs.
    byte unsigned mb [NBYTES];
    int          m_lc, m_sc;
    bit          m_err;
    bit          e_valid;
    logic [31:0] e_inst, e_alu, e_lmd;
    logic [3:0]  e_num, e_type;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int ba);
        int w;
        w = ba & ~3;
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(wb_valid), 32'(e_valid));
        chk({tag, ".inst"}, wb_inst, e_inst);
        chk({tag, ".alu"}, wb_aluout, e_alu);
        chk({tag, ".lmd"}, wb_lmd, e_lmd);
        chk({tag, ".num"}, 32'(wb_instnum), 32'(e_num));
        chk({tag, ".type"}, 32'(wb_insttype), 32'(e_type));
        chk({tag, ".err"}, 32'(misalign_err), 32'(m_err));
        chk({tag, ".lc"}, 32'(load_count), m_lc);
        chk({tag, ".sc"}, 32'(store_count), m_sc);
    endtask

    // One instruction through the stage; model updated from its rules.
    task automatic issue(input logic v, input logic [5:0] op,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic cond, input logic rst,
                         input bit chk_on, input string tag);
        int  ba;
        bit  al, br;
        @(negedge clock);
        reset       = rst;
        in_valid    = v;
        in_inst     = {op, 26'($urandom)};
        in_aluout   = addr;
        in_regdatab = data;
        in_cond     = cond;
        in_instnum  = 4'($urandom);
        in_insttype = 4'($urandom);
        #1;
        br = v && (op == 6'h04 || op == 6'h05) && cond;
        if (chk_on) begin
            chk({tag, ".bt"}, 32'(branch_taken), 32'(br));
            chk({tag, ".btgt"}, branch_target, addr);
        end
        ba = int'(addr % NBYTES);
        al = (addr[1:0] == 2'b00);
        if (rst) begin
            e_valid = 0; e_inst = 0; e_alu = 0; e_lmd = 0;
            e_num = 0; e_type = 0; m_err = 0; m_lc = 0; m_sc = 0;
        end else begin
            e_valid = v; e_inst = in_inst; e_alu = addr;
            e_num = in_instnum; e_type = in_insttype; e_lmd = 0;
            if (v) begin
                case (op)
                    6'h23: if (al) begin
                        e_lmd = mword(ba); m_lc++;
                    end else m_err = 1;
                    6'h20: begin
                        e_lmd = {{24{mb[ba][7]}}, mb[ba]}; m_lc++;
                    end
                    6'h24: begin
                        e_lmd = {24'd0, mb[ba]}; m_lc++;
                    end
                    6'h2B: if (al) begin
                        for (int k = 0; k < 4; k++)
                            mb[ba + k] = data[8*k +: 8];
                        m_sc++;
                    end else m_err = 1;
                    6'h28: begin
                        mb[ba] = data[7:0]; m_sc++;
                    end
                    default: ;
                endcase
                if (m_lc > 65535) m_lc = 65535;
                if (m_sc > 65535) m_sc = 65535;
            end
        end
        @(posedge clock);
        #1;
        if (chk_on) check_all(tag);
    endtask

    logic [5:0] ops [9] = '{6'h23, 6'h20, 6'h24, 6'h2B, 6'h28,
                            6'h04, 6'h05, 6'h00, 6'h3F};
    int lc_save;

    initial begin
        reset = 1; in_valid = 0; in_inst = 0; in_aluout = 0;
        in_regdatab = 0; in_cond = 0; in_instnum = 0; in_insttype = 0;

        // Reset state
        issue(0, 6'h00, 0, 0, 0, 1, 1, "rst");
        chk("rst.lmd0", wb_lmd, 32'd0);

        // Store then load back-to-back
        issue(1, 6'h2B, 32'h10, 32'hDEADBEEF, 0, 0, 1, "sw10");
        issue(1, 6'h23, 32'h10, 0, 0, 0, 1, "lw10");
        chk("bb.lmd", wb_lmd, 32'hDEADBEEF);
        chk("bb.sc", 32'(store_count), 32'd1);
        chk("bb.lc", 32'(load_count), 32'd1);

        // Fill the whole RAM so the model is fully known
        for (int i = 0; i < (1 << ADDR_W); i++)
            issue(1, 6'h2B, 32'(i * 4), $urandom, 0, 0, 0, "fill");

        // Byte store and sign/zero-extended byte loads
        issue(1, 6'h2B, 32'h10, 32'h11223344, 0, 0, 1, "sw_b");
        issue(1, 6'h28, 32'h13, 32'h00000080, 0, 0, 1, "sb13");
        issue(1, 6'h20, 32'h13, 0, 0, 0, 1, "lb13");
        chk("lb.lmd", wb_lmd, 32'hFFFFFF80);
        issue(1, 6'h24, 32'h13, 0, 0, 0, 1, "lbu13");
        chk("lbu.lmd", wb_lmd, 32'h00000080);
        issue(1, 6'h23, 32'h10, 0, 0, 0, 1, "lw10b");
        chk("lwb.lmd", wb_lmd, 32'h80223344);

        // Misaligned word load: flag is sticky
        lc_save = m_lc;
        issue(1, 6'h23, 32'h06, 0, 0, 0, 1, "lw06");
        chk("mis.valid", 32'(wb_valid), 32'd1);
        chk("mis.lmd", wb_lmd, 32'd0);
        chk("mis.err", 32'(misalign_err), 32'd1);
        chk("mis.lc", 32'(load_count), 32'(lc_save));
        for (int i = 0; i < 10; i++)
            issue(0, 6'h00, $urandom, 0, 0, 0, 1, "hold");
        chk("hold.err", 32'(misalign_err), 32'd1);

        // Branch resolve is combinational
        @(negedge clock);
        in_inst = {6'h04, 26'd0}; in_cond = 1;
        in_aluout = 32'h40; in_valid = 1;
        #1;
        chk("beq.bt", 32'(branch_taken), 32'd1);
        chk("beq.tgt", branch_target, 32'h40);
        in_valid = 0;
        #1;
        chk("beq.inv", 32'(branch_taken), 32'd0);
        issue(1, 6'h05, 32'h80, 0, 1, 0, 1, "bne");
        issue(1, 6'h04, 32'h80, 0, 0, 0, 1, "beq0");

        // Address wraps modulo the RAM size
        issue(1, 6'h2B, 32'h400, 32'hCAFEF00D, 0, 0, 1, "sw400");
        issue(1, 6'h23, 32'h000, 0, 0, 0, 1, "lw000");
        chk("wrap.lmd", wb_lmd, 32'hCAFEF00D);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op;
            logic [31:0] a;
            op = ops[$urandom_range(0, 8)];
            a = $urandom;
            if ((op == 6'h23 || op == 6'h2B) && $urandom_range(0, 3) != 0)
                a[1:0] = 2'b00;
            issue($urandom_range(0, 9) != 0, op, a, $urandom,
                  1'($urandom), 0, 1, "rnd");
        end

        // Reset blocks a concurrent store; RAM keeps old contents
        issue(1, 6'h2B, 32'h20, 32'h0000A5A5, 0, 0, 1, "sw20");
        issue(1, 6'h2B, 32'h20, 32'h00000005, 0, 1, 1, "rstsw");
        chk("rstsw.valid", 32'(wb_valid), 32'd0);
        chk("rstsw.sc", 32'(store_count), 32'd0);
        issue(1, 6'h23, 32'h20, 0, 0, 0, 1, "lw20");
        chk("rstsw.lmd", wb_lmd, 32'h0000A5A5);

        // Load counter saturation
        issue(0, 6'h00, 0, 0, 0, 1, 1, "rst2");
        for (int i = 0; i < 65536; i++)
            issue(1, 6'h23, 32'h0, 0, 0, 0, 0, "sat");
        chk("sat.lc", 32'(load_count), 32'h0000FFFF);
        issue(1, 6'h20, 32'h1, 0, 0, 0, 1, "sat2");
        chk("sat2.lc", 32'(load_count), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
